// File: rtl/fir_lpf_mac.sv
// Time-multiplexed FIR low-pass filter: one shared signed multiplier, loadable coefficient bank,
// valid/ready on both sides. Define FIR_LPF_SAT_EN for round-half-up plus saturation on the output.
module fir_lpf_mac #(
  parameter int DW    = 8,
  parameter int CW    = 12,
  parameter int TAPS  = 16,
  parameter int SHIFT = 0,
  parameter int OW    = 21,
  localparam int AW   = DW + CW + $clog2(TAPS),
  localparam int IW   = $clog2(TAPS)
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [OW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic          coef_we,
  input  logic [IW-1:0] coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state;
  logic signed [DW-1:0]     x [TAPS];
  logic signed [CW-1:0]     c [TAPS];
  logic signed [AW-1:0]     acc;
  logic        [IW-1:0]     idx;

  logic signed [DW+CW-1:0]  prod;
  logic signed [AW-1:0]     sum_next;
  logic        [OW-1:0]     y_fit;
  logic                     coef_ok;

`ifdef FIR_LPF_SAT_EN
  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [AW:0] RND   = (SHIFT > 0) ? ((AW+1)'(1) << SH_M1) : (AW+1)'(0);
  localparam logic signed [AW:0] Y_MAX = {{(AW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] Y_MIN = {{(AW+2-OW){1'b1}}, {(OW-1){1'b0}}};
  logic signed [AW:0] rounded;
`else
  logic signed [AW-1:0] shifted;
`endif

  assign s_ready = (state == IDLE);
  assign busy    = (state != IDLE);
  assign coef_ok = coef_we && (state == IDLE) && ({1'b0, coef_addr} < (IW+1)'(TAPS));

  // NOTE: every signal written here gets a value on every path, so no latch can be inferred.
  always_comb begin
    prod     = x[idx] * c[idx];
    sum_next = acc + AW'(prod);
`ifdef FIR_LPF_SAT_EN
    rounded  = ((AW+1)'(sum_next) + RND) >>> SHIFT;
    if (rounded > Y_MAX)      y_fit = Y_MAX[OW-1:0];
    else if (rounded < Y_MIN) y_fit = Y_MIN[OW-1:0];
    else                      y_fit = rounded[OW-1:0];
`else
    shifted  = sum_next >>> SHIFT;
    y_fit    = shifted[OW-1:0];
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      idx     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      // NOTE: delay line and coefficient bank are reset too, so a fresh filter starts from all-zero taps.
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      // A write in the handshake cycle lands before any MAC cycle reads the bank.
      if (coef_ok) c[coef_addr] <= coef_data;

      case (state)
        IDLE: begin
          if (s_valid) begin
            x[0] <= s_data;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= sum_next;
          if (idx == IW'(TAPS - 1)) begin
            idx     <= '0;
            m_data  <= y_fit;
            m_valid <= 1'b1;
            state   <= OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_lpf_mac.sv
// Self-checking bench for fir_lpf_mac: three 4-tap builds share one stimulus stream and are
// compared against a queue-based FIR model (honours FIR_LPF_SAT_EN when defined).
module tb_fir_lpf_mac;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b1;
  logic        coef_we = 1'b0;
  logic [1:0]  coef_addr = '0;
  logic [11:0] coef_data = '0;

  logic        s_ready_a, s_ready_b, s_ready_c;
  logic        m_valid_a, m_valid_b, m_valid_c;
  logic        busy_a, busy_b, busy_c;
  logic [20:0] m_data_a;
  logic [7:0]  m_data_b;
  logic [9:0]  m_data_c;

  int n_checks = 0;
  int n_errors = 0;

  int     xq[$] = '{0, 0, 0, 0};
  int     cm[4] = '{0, 0, 0, 0};
  longint last_sum;
  logic [20:0] last_a;
  logic [7:0]  last_b;

  always #5 sclk = ~sclk;

  fir_lpf_mac #(.DW(8), .CW(12), .TAPS(4), .SHIFT(0), .OW(21)) dut_a (
    .sclk(sclk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_a),
    .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy_a));

  fir_lpf_mac #(.DW(8), .CW(8), .TAPS(4), .SHIFT(0), .OW(8)) dut_b (
    .sclk(sclk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_b),
    .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data[7:0]), .busy(busy_b));

  fir_lpf_mac #(.DW(8), .CW(8), .TAPS(4), .SHIFT(3), .OW(10)) dut_c (
    .sclk(sclk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_c),
    .m_data(m_data_c), .m_valid(m_valid_c), .m_ready(m_ready), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data[7:0]), .busy(busy_c));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dot product of the newest-first sample history with the coefficient bank.
  function automatic longint fir_sum();
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(xq[k]) * longint'(cm[k]);
    return s;
  endfunction

  function automatic logic [63:0] expect_out(input longint sum, input int shift, input int ow);
    longint y;
`ifdef FIR_LPF_SAT_EN
    longint hi, lo;
    y  = (shift > 0) ? ((sum + (longint'(1) << (shift - 1))) >>> shift) : sum;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -(longint'(1) << (ow - 1));
    if (y > hi) y = hi;
    if (y < lo) y = lo;
`else
    y = sum >>> shift;
`endif
    return 64'(y) & ((64'd1 << ow) - 64'd1);
  endfunction

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 12'(v);
    @(posedge sclk); #1;
    coef_we = 1'b0;
    cm[a] = v;
  endtask

  // One sample through all DUTs; hold = cycles of m_ready=0 once the result is up.
  task automatic send(input int d, input int hold, input bit wr_hs, input bit wr_mac,
                      input int waddr, input int wdata, input bit pend_en, input int pend);
    int n;
    int lat;
    logic [20:0] held_a;
    s_data = 8'(d); s_valid = 1'b1;
    if (wr_hs) begin coef_we = 1'b1; coef_addr = 2'(waddr); coef_data = 12'(wdata); end
    n = 0;
    while (!s_ready_a && n < 40) begin @(posedge sclk); #1; n++; end
    check("hs_wait_bound", 64'(n < 40), 64'(1));
    @(posedge sclk); #1;
    s_valid = pend_en;
    if (pend_en) s_data = 8'(pend);
    coef_we = 1'b0;
    if (wr_hs) cm[waddr] = wdata;
    xq.push_front(d);
    void'(xq.pop_back());
    last_sum = fir_sum();
    m_ready = (hold == 0);
    lat = 0;
    while (!m_valid_a && lat < 20) begin
      @(posedge sclk); #1; lat++;
      if (wr_mac && lat == 1) begin
        coef_we = 1'b1; coef_addr = 2'(waddr); coef_data = 12'(wdata);
      end else begin
        coef_we = 1'b0;
      end
      if (lat == 1) begin
        check("busy_in_mac", 64'(busy_a), 64'(1));
        check("s_ready_in_mac", 64'(s_ready_a), 64'(0));
      end
    end
    check("latency", 64'(lat), 64'(4));
    check("a_data", 64'(m_data_a), expect_out(last_sum, 0, 21));
    check("b_valid", 64'(m_valid_b), 64'(1));
    check("b_data", 64'(m_data_b), expect_out(last_sum, 0, 8));
    check("c_valid", 64'(m_valid_c), 64'(1));
    check("c_data", 64'(m_data_c), expect_out(last_sum, 3, 10));
    last_a = m_data_a;
    last_b = m_data_b;
    held_a = m_data_a;
    for (int i = 0; i < hold; i++) begin
      @(posedge sclk); #1;
      check("bp_valid", 64'(m_valid_a), 64'(1));
      check("bp_data_stable", 64'(m_data_a), 64'(held_a));
      check("bp_s_ready", 64'(s_ready_a), 64'(0));
    end
    m_ready = 1'b1;
    @(posedge sclk); #1;
    check("drain_valid", 64'(m_valid_a), 64'(0));
    check("drain_s_ready", 64'(s_ready_a), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int imp_exp[4];
    int a, v, d, h, seen;
    bit hs;

    // Reset held for three edges
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1 rst_n = 1'b1;
    check("rst_m_valid", 64'(m_valid_a), 64'(0));
    check("rst_m_data", 64'(m_data_a), 64'(0));
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_s_ready", 64'(s_ready_a), 64'(1));

    // Impulse response
    imp_exp = '{1, 2, 3, 4};
    for (int k = 0; k < 4; k++) write_coef(k, k + 1);
    for (int k = 0; k < 4; k++) begin
      send((k == 0) ? 1 : 0, 0, 0, 0, 0, 0, 0, 0);
      check("impulse_literal", 64'(last_a), 64'(imp_exp[k]));
    end

    // Backpressure with a pending sample waiting
    send(7, 5, 0, 0, 0, 0, 1, -9);
    send(-9, 0, 0, 0, 0, 0, 0, 0);

    // Overflow: full-scale products
    for (int k = 0; k < 4; k++) write_coef(k, 127);
    for (int k = 0; k < 4; k++) send(127, 0, 0, 0, 0, 0, 0, 0);
    check("ovf_a_literal", 64'(last_a), 64'(64516));
`ifdef FIR_LPF_SAT_EN
    check("ovf_b_literal", 64'(last_b), 64'(127));
`else
    check("ovf_b_literal", 64'(last_b), 64'(4));
`endif

    // Signed extremes
    write_coef(0, -128);
    for (int k = 1; k < 4; k++) write_coef(k, 0);
    send(-128, 0, 0, 0, 0, 0, 0, 0);
    check("extreme_literal", 64'(last_a), 64'(16384));

    // Coefficient gating: MAC-time write dropped, handshake-time write used
    for (int k = 0; k < 4; k++) write_coef(k, k - 2);
    send(11, 0, 0, 1, 0, 5, 0, 0);
    send(-3, 0, 0, 0, 0, 0, 0, 0);
    send(20, 0, 1, 0, 0, 5, 0, 0);

    // Reset during MAC abandons the sample
    s_data = 8'(33); s_valid = 1'b1;
    @(posedge sclk); #1 s_valid = 1'b0;
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b0;
    @(posedge sclk); #1 rst_n = 1'b1;
    xq = '{0, 0, 0, 0};
    cm = '{0, 0, 0, 0};
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge sclk); #1;
      if (m_valid_a) seen = 1;
    end
    check("abandon_no_output", 64'(seen), 64'(0));
    check("abandon_busy", 64'(busy_a), 64'(0));
    send(55, 0, 0, 0, 0, 0, 0, 0);
    check("coef_reset_zero", 64'(last_a), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      a  = int'($urandom_range(3));
      v  = int'($urandom_range(255)) - 128;
      d  = int'($urandom_range(255)) - 128;
      h  = int'($urandom_range(3));
      hs = 1'($urandom_range(1));
      if (!hs) write_coef(a, v);
      send(d, h, hs, 0, a, v, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
